// File: rtl/rega_timer_pkg.sv
// Shared constants for the irrigation timer controller: FSM state encodings,
// BCD digit maxima and the preset validity check.
package rega_timer_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] PAUSED = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] US_MAX = 4'd9;
  localparam logic [3:0] DS_MAX = 4'd5;
  localparam logic [3:0] UM_MAX = 4'd9;
  localparam logic [3:0] DM_MAX = 4'd9;

  function automatic logic preset_valid(input logic [3:0] us, input logic [3:0] ds,
                                        input logic [3:0] um, input logic [3:0] dm);
    return (us <= US_MAX) && (ds <= DS_MAX) && (um <= UM_MAX) && (dm <= DM_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit. Decrements on en, reloads wrap when leaving 0,
// and raises borrow so the next more-significant digit decrements too.
module bcd_digit_down (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  input  logic [3:0] wrap,
  output logic [3:0] q,
  output logic       borrow
);

  // NOTE: state is updated with <= so every digit samples the pre-edge chain values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= (q == 4'd0) ? wrap : q - 4'd1;
    end
  end

  assign borrow = en && (q == 4'd0);

endmodule

// File: rtl/rega_timer_ctrl.sv
// Irrigation countdown sequencer: validates and loads a BCD MM:SS preset,
// counts it down on the 1 Hz tick and drives the valve while time remains.
module rega_timer_ctrl
  import rega_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] PresetUS,
  input  logic [3:0] PresetDS,
  input  logic [3:0] PresetUM,
  input  logic [3:0] PresetDM,
  output logic       init,
  output logic [3:0] CUS,
  output logic [3:0] CDS,
  output logic [3:0] CUM,
  output logic [3:0] CDM,
  output logic       valve,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  logic [2:0] state_d;
  logic       preset_ok, preset_zero, last_second;
  logic       cancel, load_digits, dec;
  logic       us_borrow, ds_borrow, um_borrow, dm_borrow;

  assign preset_ok   = preset_valid(PresetUS, PresetDS, PresetUM, PresetDM);
  assign preset_zero = ({PresetDM, PresetUM, PresetDS, PresetUS} == 16'h0000);
  assign last_second = ({CDM, CUM, CDS, CUS} == 16'h0001);

  assign cancel      = abort && (state != IDLE);
  assign load_digits = (state == LOAD) && !abort;
  // pause outranks tick, so a tick in the cycle pause rises is dropped
  assign dec         = (state == RUN) && tick && !pause && !abort;

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state;
    case (state)
      IDLE:    if (start && preset_ok) state_d = LOAD;
      LOAD:    state_d = preset_zero ? DONE : RUN;
      RUN: begin
        if (pause) begin
          state_d = PAUSED;
        end else if (tick && (last_second || dm_borrow)) begin
          // dm_borrow only fires from 00:00, which RUN never holds; stop rather than wrap
          state_d = DONE;
        end
      end
      PAUSED:  if (!pause) state_d = RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cancel) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) err <= !preset_ok;
    end
  end

  bcd_digit_down u_us (
    .clk(clk), .rst(rst), .clear(cancel), .load(load_digits), .en(dec),
    .load_val(PresetUS), .wrap(US_MAX), .q(CUS), .borrow(us_borrow)
  );
  bcd_digit_down u_ds (
    .clk(clk), .rst(rst), .clear(cancel), .load(load_digits), .en(us_borrow),
    .load_val(PresetDS), .wrap(DS_MAX), .q(CDS), .borrow(ds_borrow)
  );
  bcd_digit_down u_um (
    .clk(clk), .rst(rst), .clear(cancel), .load(load_digits), .en(ds_borrow),
    .load_val(PresetUM), .wrap(UM_MAX), .q(CUM), .borrow(um_borrow)
  );
  bcd_digit_down u_dm (
    .clk(clk), .rst(rst), .clear(cancel), .load(load_digits), .en(um_borrow),
    .load_val(PresetDM), .wrap(DM_MAX), .q(CDM), .borrow(dm_borrow)
  );

  assign init  = (state == LOAD);
  assign valve = (state == RUN) || (state == PAUSED);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_rega_timer_ctrl.sv
// Scenario bench for rega_timer_ctrl: each row drives one cycle and pushes the
// expected outputs; the scenario task pops and compares after the edge.
module tb_rega_timer_ctrl;
  import rega_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tick, start, pause, abort;
  logic [3:0] PresetUS, PresetDS, PresetUM, PresetDM;
  logic       init, valve, busy, done, err;
  logic [3:0] CUS, CDS, CUM, CDM;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0]  st;
    logic        init, valve, busy, done, err;
    logic [15:0] t;
  } obs_t;

  // stim bits: {rst, start, pause, abort, tick}
  typedef struct packed {
    logic [15:0] preset;
    logic [4:0]  stim;
    logic [2:0]  st;
    logic        err;
    logic [15:0] t;
  } row_t;

  obs_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  rega_timer_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .abort(abort),
    .PresetUS(PresetUS), .PresetDS(PresetDS), .PresetUM(PresetUM), .PresetDM(PresetDM),
    .init(init), .CUS(CUS), .CDS(CDS), .CUM(CUM), .CDM(CDM),
    .valve(valve), .busy(busy), .done(done), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [2:0] st, input logic e, input logic [15:0] t);
    obs_t o;
    o.st    = st;
    o.init  = (st == LOAD);
    o.valve = (st == RUN) || (st == PAUSED);
    o.busy  = (st != IDLE);
    o.done  = (st == DONE);
    o.err   = e;
    o.t     = t;
    return o;
  endfunction

  function automatic row_t r(input logic [15:0] p, input logic [4:0] s,
                             input logic [2:0] st, input logic e, input logic [15:0] t);
    row_t x;
    x.preset = p;
    x.stim   = s;
    x.st     = st;
    x.err    = e;
    x.t      = t;
    return x;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.st    = state;
    o.init  = init;
    o.valve = valve;
    o.busy  = busy;
    o.done  = done;
    o.err   = err;
    o.t     = {CDM, CUM, CDS, CUS};
    return o;
  endfunction

  task automatic drive(input row_t x);
    {PresetDM, PresetUM, PresetDS, PresetUS} = x.preset;
    {rst, start, pause, abort, tick}         = x.stim;
    exp_q.push_back(mk(x.st, x.err, x.t));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t q[$];
    obs_t e, g;
    q.push_back(r(16'h0003, 5'b11111, IDLE, 1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b10000, IDLE, 1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b00000, IDLE, 1'b0, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      e = exp_q.pop_front();
      g = observed();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: {st,init,valve,busy,done,err,MMSS} got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_countdown();
    row_t q[$];
    obs_t e, g;
    q.push_back(r(16'h0003, 5'b01000, LOAD, 1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b00001, RUN,  1'b0, 16'h0003));
    q.push_back(r(16'h0003, 5'b00001, RUN,  1'b0, 16'h0002));
    q.push_back(r(16'h0003, 5'b00000, RUN,  1'b0, 16'h0002));
    q.push_back(r(16'h0003, 5'b01001, RUN,  1'b0, 16'h0001));
    q.push_back(r(16'h0003, 5'b00001, DONE, 1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b00001, IDLE, 1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b00000, IDLE, 1'b0, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      e = exp_q.pop_front();
      g = observed();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL countdown[%0d]: {st,init,valve,busy,done,err,MMSS} got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_wrap();
    row_t q[$];
    obs_t e, g;
    q.push_back(r(16'h0100, 5'b01000, LOAD, 1'b0, 16'h0000));
    q.push_back(r(16'h0100, 5'b00000, RUN,  1'b0, 16'h0100));
    q.push_back(r(16'h0100, 5'b00001, RUN,  1'b0, 16'h0059));
    q.push_back(r(16'h0100, 5'b00111, IDLE, 1'b0, 16'h0000));
    q.push_back(r(16'h1000, 5'b01000, LOAD, 1'b0, 16'h0000));
    q.push_back(r(16'h1000, 5'b00000, RUN,  1'b0, 16'h1000));
    q.push_back(r(16'h1000, 5'b00001, RUN,  1'b0, 16'h0959));
    q.push_back(r(16'h1000, 5'b00010, IDLE, 1'b0, 16'h0000));
    q.push_back(r(16'h9959, 5'b01000, LOAD, 1'b0, 16'h0000));
    q.push_back(r(16'h9959, 5'b00000, RUN,  1'b0, 16'h9959));
    q.push_back(r(16'h9959, 5'b00001, RUN,  1'b0, 16'h9958));
    q.push_back(r(16'h9959, 5'b00010, IDLE, 1'b0, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      e = exp_q.pop_front();
      g = observed();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: {st,init,valve,busy,done,err,MMSS} got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_pause_abort();
    row_t q[$];
    obs_t e, g;
    q.push_back(r(16'h0005, 5'b01000, LOAD,   1'b0, 16'h0000));
    q.push_back(r(16'h0005, 5'b00000, RUN,    1'b0, 16'h0005));
    q.push_back(r(16'h0005, 5'b00101, PAUSED, 1'b0, 16'h0005));
    q.push_back(r(16'h0005, 5'b00101, PAUSED, 1'b0, 16'h0005));
    q.push_back(r(16'h0005, 5'b00101, PAUSED, 1'b0, 16'h0005));
    q.push_back(r(16'h0005, 5'b00000, RUN,    1'b0, 16'h0005));
    q.push_back(r(16'h0005, 5'b00001, RUN,    1'b0, 16'h0004));
    q.push_back(r(16'h0005, 5'b00010, IDLE,   1'b0, 16'h0000));
    q.push_back(r(16'h0005, 5'b00000, IDLE,   1'b0, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      e = exp_q.pop_front();
      g = observed();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL pause_abort[%0d]: {st,init,valve,busy,done,err,MMSS} got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_zero_preset();
    row_t q[$];
    obs_t e, g;
    q.push_back(r(16'h0000, 5'b01000, LOAD, 1'b0, 16'h0000));
    q.push_back(r(16'h0000, 5'b00001, DONE, 1'b0, 16'h0000));
    q.push_back(r(16'h0000, 5'b00000, IDLE, 1'b0, 16'h0000));
    q.push_back(r(16'h0000, 5'b00000, IDLE, 1'b0, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      e = exp_q.pop_front();
      g = observed();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL zero_preset[%0d]: {st,init,valve,busy,done,err,MMSS} got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_invalid();
    row_t q[$];
    obs_t e, g;
    q.push_back(r(16'h0060, 5'b01000, IDLE, 1'b1, 16'h0000));
    q.push_back(r(16'h0060, 5'b00000, IDLE, 1'b1, 16'h0000));
    q.push_back(r(16'h000A, 5'b01000, IDLE, 1'b1, 16'h0000));
    q.push_back(r(16'hA000, 5'b01000, IDLE, 1'b1, 16'h0000));
    q.push_back(r(16'h0002, 5'b01000, LOAD, 1'b0, 16'h0000));
    q.push_back(r(16'h0002, 5'b00000, RUN,  1'b0, 16'h0002));
    q.push_back(r(16'h0002, 5'b00001, RUN,  1'b0, 16'h0001));
    q.push_back(r(16'h0002, 5'b00001, DONE, 1'b0, 16'h0000));
    q.push_back(r(16'h0002, 5'b00000, IDLE, 1'b0, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      e = exp_q.pop_front();
      g = observed();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL invalid[%0d]: {st,init,valve,busy,done,err,MMSS} got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_rst_paused();
    row_t q[$];
    obs_t e, g;
    q.push_back(r(16'h0005, 5'b01000, LOAD,   1'b0, 16'h0000));
    q.push_back(r(16'h0005, 5'b00000, RUN,    1'b0, 16'h0005));
    q.push_back(r(16'h0005, 5'b00101, PAUSED, 1'b0, 16'h0005));
    q.push_back(r(16'h0005, 5'b10100, IDLE,   1'b0, 16'h0000));
    q.push_back(r(16'h0005, 5'b00100, IDLE,   1'b0, 16'h0000));
    q.push_back(r(16'h0070, 5'b01000, IDLE,   1'b1, 16'h0000));
    q.push_back(r(16'h0070, 5'b10000, IDLE,   1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b01000, LOAD,   1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b00001, RUN,    1'b0, 16'h0003));
    q.push_back(r(16'h0003, 5'b10001, IDLE,   1'b0, 16'h0000));
    q.push_back(r(16'h0003, 5'b00000, IDLE,   1'b0, 16'h0000));
    foreach (q[i]) begin
      drive(q[i]);
      e = exp_q.pop_front();
      g = observed();
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rst_paused[%0d]: {st,init,valve,busy,done,err,MMSS} got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    {rst, start, pause, abort, tick} = 5'b10000;
    {PresetDM, PresetUM, PresetDS, PresetUS} = 16'h0000;
    #1;
    test_reset();
    test_countdown();
    test_wrap();
    test_pause_abort();
    test_zero_preset();
    test_invalid();
    test_rst_paused();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rega_timer_ctrl.md
# rega_timer_ctrl

Sequencing controller for the irrigation countdown timer: captures a BCD MM:SS preset, counts it down on a 1 Hz tick, and drives the valve while time remains. It generates the `init` gating pulse consumed by the timer's clear/preset gating stage and owns the four BCD digit registers (units/tens of seconds, units/tens of minutes). It sits between the user-facing setup logic and the valve/display outputs of the watering system.

## Interface
- No parameters. Digit limits are fixed package constants.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle 1 Hz enable pulse.
- `start` in 1: request a watering cycle; sampled in IDLE only.
- `pause` in 1: level; holds the countdown while high.
- `abort` in 1: cancels the cycle from any state.
- `PresetUS`, `PresetDS`, `PresetUM`, `PresetDM` in 4 each: BCD preset digits.
- `init` out 1: one-cycle gating strobe asserted during LOAD.
- `CUS`, `CDS`, `CUM`, `CDM` out 4 each: current remaining time, BCD.
- `valve` out 1: high in RUN and PAUSED.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on natural expiry only.
- `err` out 1: sticky invalid-preset flag; cleared by the next accepted `start` or by `rst`.
- `state` out 3: current FSM state encoding, for debug and display.

## Operation
- States: IDLE, LOAD, RUN, PAUSED, DONE.
- IDLE:
  - `start` with a valid preset -> LOAD.
  - `start` with an invalid preset (US>9, DS>5, UM>9, DM>9) -> stay in IDLE, set `err`.
- LOAD:
  - `init`=1.
  - Digit registers take the preset digits.
  - If the preset is 00:00 -> DONE, else -> RUN.
- RUN, on `tick`:
  - Decrement MM:SS as a BCD borrow chain.
  - US 0->9 borrows from DS; DS 0->5 borrows from UM; UM 0->9 borrows from DM.
  - When the value becomes 00:00 -> DONE in the same edge.
- RUN with `pause`=1 -> PAUSED; no decrement that cycle, even if `tick` is also high.
- PAUSED: digits hold; `pause`=0 -> RUN.
- DONE: `done`=1 for exactly one cycle, `valve`=0, digits hold 00:00; -> IDLE.
- `abort` in any non-IDLE state: -> IDLE, digits cleared to 0, no `done`.
- Priority within a cycle: `rst` > `abort` > `pause` > `tick`.
- `start` is ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, all digits 0.
  - `init`, `valve`, `busy`, `done`, `err` = 0.
- Latency:
  - `start` sampled at edge N -> `init` high in cycle N+1 -> digits loaded and `valve` high from N+2.
  - The `tick` arriving in the LOAD cycle is ignored.
- Run length: a preset of T seconds expires on the T-th `tick` accepted in RUN. That tick's edge shows 00:00 and DONE; `valve` falls at that same edge.
- `done` is asserted for the single cycle the FSM spends in DONE; `busy` falls on the following edge.
- `rst` asserted mid-RUN returns all outputs to reset values at the next edge.
- All outputs are registered or decoded directly from state.

## Structure
- Package `rega_timer_pkg`:
  - State encoding localparams: IDLE=0, LOAD=1, RUN=2, PAUSED=3, DONE=4.
  - Digit maxima: US_MAX=9, DS_MAX=5, UM_MAX=9, DM_MAX=9.
- Sub-module `bcd_digit_down`: a single 4-bit BCD down-counter with load, clear, enable/borrow-in, borrow-out and a wrap-value input.
  - Four instances are chained US->DS->UM->DM.
- The FSM and preset validation stay in the top module.

## Test plan
- Preset 00:03, `start`:
  - `init` pulses once.
  - `valve` high; 3 ticks show 00:02, 00:01, 00:00.
  - `done` pulses once, then IDLE.
- Preset 01:00, one tick -> 00:59 (DS wrap to 5, US wrap to 9). Preset 10:00, one tick -> 09:59.
- Preset 00:05:
  - `pause` high across 3 ticks -> value stays 00:05, `valve` stays 1.
  - Release `pause` -> the next tick gives 00:04.
  - A tick coincident with `pause` rising is not counted.
- Preset 00:00 -> LOAD -> DONE: `done` pulses, `valve` never rises.
- Invalid preset DS=6 -> `err`=1, state stays IDLE. A later valid `start` clears `err` and proceeds.
- `abort` in RUN at 00:04 -> next cycle IDLE, digits 00:00, no `done`. `rst` during PAUSED -> all reset values.
